// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Brief    : Multicycle shift-add multiply / restoring divide sequencer that
//            owns the HI/LO write port and stalls MFHI/MFLO while busy.
//            Optional signed MULT/DIV support: define SIGNED_MD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 read_req,
  output logic                 busy,
  output logic                 done,
  output logic                 hilo_we,
  output logic [2*WIDTH-1:0]   hilo_d,
  output logic                 div_by_zero,
  output logic                 stall
);

  localparam int              c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_is_div;
  logic                 r_bz;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_hilo_hold;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_a_in;
  logic [WIDTH-1:0]     w_b_in;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_res;

  // Operand conditioning: the core always sees unsigned magnitudes.
`ifdef SIGNED_MD_EN
  logic r_sa;
  logic r_sb;
  logic w_sa;
  logic w_sb;

  always_comb begin
    w_sa   = op[1] & a[WIDTH-1];
    w_sb   = op[1] & b[WIDTH-1];
    w_a_in = w_sa ? -a : a;
    w_b_in = w_sb ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (w_accept) begin
      r_sa <= w_sa;
      r_sb <= w_sb;
    end
  end

  // Zero divisor keeps the all-ones quotient unnegated so LO stays all ones.
  always_comb begin
    w_res = {r_hi, r_lo};
    if (!r_is_div) begin
      if (r_sa ^ r_sb) w_res = -{r_hi, r_lo};
    end else begin
      w_res[WIDTH-1:0]       = ((r_sa ^ r_sb) && !r_bz) ? -r_lo : r_lo;
      w_res[2*WIDTH-1:WIDTH] = r_sa ? -r_hi : r_hi;
    end
  end
`else
  logic w_unused_op1;

  always_comb begin
    w_a_in       = a;
    w_b_in       = b;
    w_res        = {r_hi, r_lo};
    w_unused_op1 = op[1];
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    hilo_we     = 1'b0;
    div_by_zero = 1'b0;
    hilo_d      = r_hilo_hold;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_LAST) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        done        = 1'b1;
        hilo_we     = 1'b1;
        hilo_d      = w_res;
        div_by_zero = r_is_div & r_bz;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    stall = read_req & (busy | w_accept);
  end

  // One iteration per RUN cycle; multiplier/quotient share r_lo.
  always_comb begin
    w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_m});
    w_diff  = w_shift[WIDTH-1:0] - r_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_bz        <= 1'b0;
      r_m         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_hilo_hold <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= op[0];
        r_bz     <= (b == '0);
        r_m      <= op[0] ? w_b_in : w_a_in;
        r_lo     <= op[0] ? w_a_in : w_b_in;
        r_hi     <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_ge};
        end else begin
          r_hi <= w_sum[WIDTH:1];
          r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
        end
      end
      if (r_state == S_WRITE) r_hilo_hold <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Brief    : Self-checking bench for hilo_muldiv_ctrl (table vectors plus
//            stall, ignored-start and reset-abort sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          read_req;
  logic          busy;
  logic          done;
  logic          hilo_we;
  logic [2*W-1:0] hilo_d;
  logic          div_by_zero;
  logic          stall;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] hilo;
    logic           dbz;
  } vec_t;

  vec_t vecs[16];
  int   n_vecs;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .read_req    (read_req),
    .busy        (busy),
    .done        (done),
    .hilo_we     (hilo_we),
    .hilo_d      (hilo_d),
    .div_by_zero (div_by_zero),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] h, input logic z);
    vecs[n_vecs] = '{op: o, a: va, b: vb, hilo: h, dbz: z};
    n_vecs++;
  endtask

  // Issue one operation from IDLE and check latency, result and return to IDLE.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2*W-1:0] exp_hilo, input logic exp_dbz, input string tag);
    int cyc;
    int nbusy;
    op = o; a = va; b = vb; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    nbusy = 0;
    while (hilo_we !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) nbusy++;
      step();
      cyc++;
    end
    if (busy === 1'b1) nbusy++;
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " busy cycles"}, 64'(nbusy), 64'd33);
    check({tag, " hilo_d"}, hilo_d, exp_hilo);
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
    check({tag, " done"}, 64'(done), 64'd1);
    step();
    check({tag, " idle we/done/busy"}, {61'd0, hilo_we, done, busy}, 64'd0);
    check({tag, " hilo hold"}, hilo_d, exp_hilo);
  endtask

  initial begin
    int errs;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; read_req = 1'b1;
    step();
    step();
    check("reset outputs", {59'd0, busy, done, hilo_we, div_by_zero, stall}, 64'd0);
    check("reset hilo_d", hilo_d, 64'd0);
    reset = 1'b0;
    read_req = 1'b0;
    step();

    n_vecs = 0;
    add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    add_vec(2'b01, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0);
    add_vec(2'b01, 32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, 1'b1);
    add_vec(2'b00, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 1'b0);
    add_vec(2'b01, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 1'b0);
    add_vec(2'b01, 32'd5,         32'd9,         64'h0000_0005_0000_0000, 1'b0);
    add_vec(2'b00, 32'd0,         32'h0000_DEAD, 64'h0,                   1'b0);
`ifdef SIGNED_MD_EN
    add_vec(2'b10, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    add_vec(2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    add_vec(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    add_vec(2'b11, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b1);
`else
    add_vec(2'b10, 32'd2,         32'd3,         64'h6,                   1'b0);
    add_vec(2'b11, 32'd7,         32'd2,         64'h0000_0001_0000_0003, 1'b0);
    add_vec(2'b11, 32'hFFFF_FFF9, 32'd2,         64'h0000_0001_7FFF_FFFC, 1'b0);
`endif

    for (int i = 0; i < n_vecs; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo, vecs[i].dbz, $sformatf("vec%0d", i));

    // Stall across a MULTU 3*5 with a late start that must be ignored.
    read_req = 1'b1;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    #1;
    check("stall start cycle", 64'(stall), 64'd1);
    errs = 0;
    for (int c = 1; c <= 33; c++) begin
      step();
      start = 1'b0;
      if (c == 5) begin
        op = 2'b01; a = 32'd77; b = 32'd7; start = 1'b1;
        #1;
      end
      if (stall !== 1'b1) errs++;
    end
    start = 1'b0;
    check("stall while busy", 64'(errs), 64'd0);
    check("stall seq write", {62'd0, hilo_we, done}, 64'd3);
    check("stall seq result", hilo_d, 64'hF);
    step();
    check("stall released", 64'(stall), 64'd0);
    check("stall seq idle busy", 64'(busy), 64'd0);
    read_req = 1'b0;

    // Reset during a divide aborts it without a HI/LO write.
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", {62'd0, busy, hilo_we}, 64'd0);
    check("abort hilo_d", hilo_d, 64'd0);
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (hilo_we !== 1'b0) errs++;
      step();
    end
    check("abort no write", 64'(errs), 64'd0);
    run_op(2'b00, 32'd2, 32'd2, 64'd4, 1'b0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
